// File: rtl/muldiv_pkg.sv
// Shared decoder codes and state/op encodings for the execute-stage HI/LO unit.
package muldiv_pkg;

  localparam logic [3:0] ALU_MULT = 4'b1000;
  localparam logic [3:0] ALU_DIV  = 4'b1001;
  localparam logic [3:0] ALU_MFHI = 4'b1010;
  localparam logic [3:0] ALU_MFLO = 4'b1011;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_e;

  typedef enum logic {
    OP_MUL,
    OP_DIV
  } op_e;

  // All four HI/LO opcodes share the 10xx prefix.
  function automatic logic is_hilo_op(input logic [3:0] alu);
    return alu[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One unsigned iteration: shift-add multiply or restoring divide on the {upper,lower} accumulator.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  op_e                  op_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [2*WIDTH-1:0]   acc_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] part;
  logic [WIDTH:0] trial;

  // Multiply: acc = {partial product, remaining multiplier}; divide: acc = {remainder, dividend/quotient}.
  always_comb begin
    sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, b_i} : {(WIDTH+1){1'b0}});
    part  = acc_i[2*WIDTH-1:WIDTH-1];
    trial = part - {1'b0, b_i};
    if (op_i == OP_MUL) begin
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end else if (trial[WIDTH]) begin
      acc_o = {part[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
    end else begin
      acc_o = {trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed MULT/DIV owning HI/LO, with MFHI/MFLO readout and pipeline stall.
// Define MULDIV_FAST_MULT_EN for a single-cycle combinational MULT (DIV stays iterative).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [3:0]       alucontrol,
  input  logic             hien,
  input  logic             loen,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_a_q, neg_a_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;

  logic               accept;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] step_acc;
  logic [2*WIDTH-1:0] mul_mag, mul_res;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op_i  (op_q),
    .acc_i (acc_q),
    .b_i   (b_q),
    .acc_o (step_acc)
  );

  // The fast path multiplies the latched magnitudes directly in FIX.
  always_comb begin
`ifdef MULDIV_FAST_MULT_EN
    mul_mag = {{WIDTH{1'b0}}, b_q} * {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
`else
    mul_mag = acc_q;
`endif
    mul_res = neg_res_q ? -mul_mag : mul_mag;
  end

  always_comb begin
    accept = en & hien & loen & ((alucontrol == ALU_MULT) | (alucontrol == ALU_DIV));
    abs_a  = srca[WIDTH-1] ? -srca : srca;
    abs_b  = srcb[WIDTH-1] ? -srcb : srcb;

    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    b_d       = b_q;
    neg_res_d = neg_res_q;
    neg_a_d   = neg_a_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d     = CW'(WIDTH - 1);
          neg_res_d = srca[WIDTH-1] ^ srcb[WIDTH-1];
          neg_a_d   = srca[WIDTH-1];
          state_d   = RUN;
          if (alucontrol == ALU_MULT) begin
            op_d  = OP_MUL;
            b_d   = abs_a;
            acc_d = {{WIDTH{1'b0}}, abs_b};
`ifdef MULDIV_FAST_MULT_EN
            state_d = FIX;
`endif
          end else begin
            op_d  = OP_DIV;
            b_d   = abs_b;
            acc_d = {{WIDTH{1'b0}}, abs_a};
          end
        end
      end
      RUN: begin
        acc_d = step_acc;
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      FIX: begin
        // Divide-by-zero needs no special case: the restoring loop yields q=all-ones, r=|srca|.
        if (op_q == OP_MUL) begin
          hi_d = mul_res[2*WIDTH-1:WIDTH];
          lo_d = mul_res[WIDTH-1:0];
        end else begin
          lo_d = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          hi_d = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      op_q      <= OP_MUL;
      cnt_q     <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      neg_res_q <= 1'b0;
      neg_a_q   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      neg_res_q <= neg_res_d;
      neg_a_q   <= neg_a_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    case (alucontrol)
      ALU_MFHI: result = hi_q;
      ALU_MFLO: result = lo_q;
      default:  result = '0;
    endcase
  end

  assign busy  = busy_q;
  assign stall = busy_q & en & is_hilo_op(alucontrol);
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus stall, back-to-back and reset-abort sequences.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [3:0]   alucontrol;
  logic         hien;
  logic         loen;
  logic [W-1:0] srca;
  logic [W-1:0] srcb;
  logic [W-1:0] result;
  logic         busy;
  logic         stall;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .alucontrol (alucontrol),
    .hien       (hien),
    .loen       (loen),
    .srca       (srca),
    .srcb       (srcb),
    .result     (result),
    .busy       (busy),
    .stall      (stall),
    .hi         (hi),
    .lo         (lo)
  );

  typedef struct {
    logic [3:0]  alu;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[12];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic idle_inputs;
    en = 1'b0;
    hien = 1'b0;
    loen = 1'b0;
    alucontrol = 4'b0000;
  endtask

  task automatic issue(input logic [3:0] alu, input logic [31:0] a, input logic [31:0] b);
    en = 1'b1;
    hien = 1'b1;
    loen = 1'b1;
    alucontrol = alu;
    srca = a;
    srcb = b;
  endtask

  function automatic int exp_lat(input logic [3:0] alu);
`ifdef MULDIV_FAST_MULT_EN
    if (alu == ALU_MULT) return 1;
`endif
    return W + 1;
  endfunction

  // Counts busy cycles from the current cycle until busy falls, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      tick;
      n++;
    end
  endtask

  initial begin
    int n;
    int cyc;
    int bad;

    vecs[0]  = '{ALU_MULT, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{ALU_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[2]  = '{ALU_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[3]  = '{ALU_DIV,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF};
    vecs[4]  = '{ALU_DIV,  32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'h00000001};
    vecs[5]  = '{ALU_MULT, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[6]  = '{ALU_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[7]  = '{ALU_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[8]  = '{ALU_DIV,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    vecs[9]  = '{ALU_DIV,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[10] = '{ALU_MULT, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000};
    vecs[11] = '{ALU_MULT, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};

    // Reset while idle.
    reset = 1'b0;
    idle_inputs();
    srca = '0;
    srcb = '0;
    repeat (2) tick;
    en = 1'b1;
    alucontrol = ALU_MFHI;
    #1;
    chk("reset_result_mfhi", result, 32'h0);
    chk("reset_stall", 32'(stall), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    tick;
    reset = 1'b1;
    alucontrol = ALU_MFLO;
    #1;
    chk("idle_result_mflo", result, 32'h0);
    idle_inputs();
    tick;

    // Vector table.
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].alu, vecs[i].a, vecs[i].b);
      tick;
      idle_inputs();
      srca = ~vecs[i].a;
      srcb = ~vecs[i].b;
      wait_idle(n);
      chk($sformatf("vec%0d_latency", i), 32'(n), 32'(exp_lat(vecs[i].alu)));
      chk($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
      chk($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
      en = 1'b1;
      alucontrol = ALU_MFHI;
      #1;
      chk($sformatf("vec%0d_mfhi", i), result, vecs[i].exp_hi);
      alucontrol = ALU_MFLO;
      #1;
      chk($sformatf("vec%0d_mflo", i), result, vecs[i].exp_lo);
      $display("vec %0d alu=%b a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h busy_cycles=%0d",
               i, vecs[i].alu, vecs[i].a, vecs[i].b, hi, lo, n);
      idle_inputs();
      tick;
    end

    // MFLO issued at cycle 5 of a MULT stalls until busy falls.
    issue(ALU_MULT, 32'h00000007, 32'hFFFFFFFD);
    tick;
    idle_inputs();
    srca = 32'hDEADBEEF;
    repeat (4) tick;
    en = 1'b1;
    alucontrol = ALU_MFLO;
    #1;
    cyc = 5;
    bad = 0;
    while (busy === 1'b1 && cyc < 200) begin
      if (stall !== 1'b1) bad++;
      tick;
      cyc++;
    end
`ifdef MULDIV_FAST_MULT_EN
    chk("mflo_stall_release_cycle", 32'(cyc), 32'd5);
`else
    chk("mflo_stall_release_cycle", 32'(cyc), 32'd34);
`endif
    chk("mflo_stall_held", 32'(bad), 32'h0);
    chk("mflo_stall_released", 32'(stall), 32'h0);
    chk("mflo_after_busy", result, 32'hFFFFFFEB);
    $display("seq mflo-during-mult: released at cycle %0d result=0x%08h", cyc, result);
    idle_inputs();
    tick;

    // Back-to-back MULT then DIV with an ADD flowing while busy.
    issue(ALU_MULT, 32'h00010000, 32'h00010000);
    tick;
    en = 1'b1;
    hien = 1'b0;
    loen = 1'b0;
    alucontrol = 4'b0010;
    #1;
    chk("add_no_stall", 32'(stall), 32'h0);
    tick;
    issue(ALU_DIV, 32'h00000064, 32'h00000007);
    #1;
    bad = 0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      if (stall !== 1'b1) bad++;
      tick;
      cyc++;
    end
    chk("div_stall_held", 32'(bad), 32'h0);
    chk("div_stall_released", 32'(stall), 32'h0);
    chk("b2b_mult_hi", hi, 32'h00000001);
    chk("b2b_mult_lo", lo, 32'h00000000);
    tick;
    idle_inputs();
    chk("b2b_div_accepted", 32'(busy), 32'h1);
    wait_idle(n);
    chk("b2b_div_latency", 32'(n), 32'(W + 1));
    chk("b2b_div_hi", hi, 32'h00000002);
    chk("b2b_div_lo", lo, 32'h0000000E);
    $display("seq back-to-back: hi=0x%08h lo=0x%08h", hi, lo);
    tick;

    // Reset pulse at cycle 10 of a MULT aborts it.
    issue(ALU_MULT, 32'h00000007, 32'hFFFFFFFD);
    tick;
    idle_inputs();
    repeat (9) tick;
    #2;
    reset = 1'b0;
    #1;
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    tick;
    reset = 1'b1;
    repeat (40) tick;
    chk("abort_no_late_busy", 32'(busy), 32'h0);
    chk("abort_no_late_hi", hi, 32'h0);
    chk("abort_no_late_lo", lo, 32'h0);
    $display("seq reset-abort: hi=0x%08h lo=0x%08h busy=%0b", hi, lo, busy);

    // Non-starting requests: en=0, unknown opcode, partial write enables.
    issue(ALU_MULT, 32'h00000003, 32'h00000004);
    en = 1'b0;
    tick;
    chk("en0_no_start", 32'(busy), 32'h0);
    issue(4'b1100, 32'h00000003, 32'h00000004);
    tick;
    chk("unknown_op_no_start", 32'(busy), 32'h0);
    issue(ALU_MULT, 32'h00000003, 32'h00000004);
    loen = 1'b0;
    tick;
    chk("partial_en_no_start", 32'(busy), 32'h0);
    idle_inputs();
    repeat (40) tick;
    chk("no_start_lo", lo, 32'h0);
    $display("seq no-start: busy=%0b hi=0x%08h lo=0x%08h", busy, hi, lo);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Execute-stage HI/LO unit. It consumes the ALU-decoder control word (alucontrol, hien, loen) and the operands.
- Runs signed MULT/DIV iteratively and owns the HI/LO registers.
- Returns the HI or LO value for MFHI/MFLO.
- Asserts stall to the hazard unit while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  EX-stage instruction valid (not bubble/flushed).
- alucontrol  in  4  decoder op: 1000 MULT, 1001 DIV, 1010 MFHI, 1011 MFLO; others are ignored.
- hien  in  1  HI write enable; both HI and LO are updated only when hien&loen.
- loen  in  1  LO write enable.
- srca  in  WIDTH  rs operand (multiplicand / dividend).
- srcb  in  WIDTH  rt operand (multiplier / divisor).
- result  out  WIDTH  HI on MFHI, LO on MFLO, else 0; combinational.
- busy  out  1  operation in flight.
- stall  out  1  combinational; hold the pipeline.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset=0, async): state=IDLE, hi=0, lo=0, counter=0, busy=0. Consequently stall=0 and result=0.
- Accept: in IDLE with en & hien & loen & alucontrol∈{MULT,DIV}.
  - Latch |srca|, |srcb| and the sign flags.
  - Go to RUN with counter=WIDTH-1. busy rises next cycle.
- RUN, one step per cycle:
  - MULT: shift-add on a 2*WIDTH product.
  - DIV: restoring step on remainder/quotient.
  - When counter==0 go to FIX; otherwise decrement the counter.
- FIX, one cycle:
  - Sign-correct the results.
  - Write HI/LO at the end of the cycle; return to IDLE.
  - busy deasserts the cycle after FIX.
- Latency: accept at cycle 0. busy is high cycles 1..WIDTH+1. New hi/lo are visible from cycle WIDTH+2 (34 for WIDTH=32).
- Sign rules:
  - MULT: product negated iff signs differ. {hi,lo} = 64-bit two's-complement product.
  - DIV: lo = quotient, negated iff signs differ. hi = remainder, carrying the sign of srca.
  - -2^31 / -1 gives lo=0x80000000, hi=0.
- Divide by zero (srcb==0): hi=srca; lo=0xFFFFFFFF if srca≥0, else 0x00000001. The full latency still applies.
- stall = busy & en & alucontrol∈{MULT,DIV,MFHI,MFLO}. Non-HI/LO instructions flow freely while busy.
- While busy, a second MULT/DIV is stalled, not accepted. It is accepted in the first cycle busy=0.
- MFHI/MFLO in IDLE: result reflects the current hi/lo the same cycle. No stall.
- MFHI/MFLO in the cycle busy falls sees the new values.
- Simultaneous events:
  - en=0 never starts an operation.
  - srca/srcb changes after accept have no effect.
- Reset mid-operation: aborts immediately. hi/lo go to 0 and the partial result is discarded.
- Decoder x on hien/loen for unknown funct: treated as no-op when en=0. With en=1, an unknown alucontrol is ignored.

Optional Feature:
- Macro MULDIV_FAST_MULT_EN.
- Defined: MULT uses a single-cycle combinational multiplier.
  - Accept goes straight to FIX; hi/lo are visible at cycle 2.
  - busy is high only in cycle 1.
  - DIV is unchanged.
- Undefined: iterative WIDTH-cycle multiply as above. No multiplier is inferred.

Decomposition:
- Package muldiv_pkg holds:
  - alucontrol localparams ALU_MULT=4'b1000, ALU_DIV=4'b1001, ALU_MFHI=4'b1010, ALU_MFLO=4'b1011.
  - state enum {IDLE, RUN, FIX}.
  - op enum {OP_MUL, OP_DIV}.
- Sub-module muldiv_step: combinational single iteration.
  - Multiply: conditional add + shift.
  - Divide: trial subtract + shift + quotient bit.
  - Selected by op; instantiated once.

Test Plan:
- Reset while idle, then MFHI/MFLO -> result=0, stall=0, hi=lo=0.
- MULT srca=0x00000007, srcb=0xFFFFFFFD (-3) -> busy cycles 1..33; at cycle 34 hi=0xFFFFFFFF, lo=0xFFFFFFEB. MFLO issued at cycle 5 stalls until busy=0, then returns 0xFFFFFFEB.
- DIV srca=0xFFFFFFF9 (-7), srcb=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV srca=5, srcb=0 -> hi=5, lo=0xFFFFFFFF. srca=-5, srcb=0 -> hi=0xFFFFFFFB, lo=1.
- Back-to-back MULT then DIV, plus an ADD (alucontrol=0010) during busy:
  - ADD: stall=0.
  - DIV: stall=1 until busy falls, then accepted.
  - Reset pulse at cycle 10 of a MULT -> hi=lo=0, busy=0, no later write.
- With MULDIV_FAST_MULT_EN: MULT 0x10000 × 0x10000 -> hi=1, lo=0 visible at cycle 2, busy high one cycle.
